// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot/reset sequencer.
package boot_seq_pkg;

    // Sequencer states, in the order a clean power-up walks through them.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        FETCH_DLY = 3'd4,
        RUN       = 3'd5
    } seq_state_t;

    // Encoding of the reset_cause output; value 3 is never produced.
    typedef logic [1:0] reset_cause_t;
    localparam reset_cause_t CAUSE_POR       = 2'd0;
    localparam reset_cause_t CAUSE_LOCK_LOSS = 2'd1;
    localparam reset_cause_t CAUSE_SOFTWARE  = 2'd2;

    // Larger of two integers, used to size the shared cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it lives inside the
        // edge-triggered block rather than in the sensitivity list.
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make meta and q update together,
            // giving a true two-stage pipeline instead of a single flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/boot_reset_seq.sv
// Reset/boot sequencer: filters PLL lock, stretches reset, releases domain
// resets in a staggered order, then enables instruction fetch.
module boot_reset_seq
    import boot_seq_pkg::*;
#(
    parameter int          NUM_DOMAINS        = 2,
    parameter int          LOCK_FILTER_CYCLES = 16,
    parameter int          RESET_HOLD_CYCLES  = 64,
    parameter int          STAGGER_CYCLES     = 8,
    parameter int          FETCH_DELAY_CYCLES = 32,
    parameter logic [31:0] BOOT_ADDR          = 32'h1A00_0080,
    parameter logic [31:0] ALT_BOOT_ADDR      = 32'h1C00_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    input  logic                   boot_sel,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   fetch_enable,
    output logic [31:0]            boot_addr,
    output logic [1:0]             reset_cause,
    output logic                   seq_busy
);

    // The shared counter must reach the longest dwell of any state.
    localparam int CNT_MAX = max_int(max_int(max_int(LOCK_FILTER_CYCLES, RESET_HOLD_CYCLES),
                                             max_int(STAGGER_CYCLES, FETCH_DELAY_CYCLES)),
                                     NUM_DOMAINS * STAGGER_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Last counter value of each timed state; the transition fires on it.
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_DOMAINS - 1) * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] FETCH_LAST   = CNT_W'(FETCH_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;

    logic                   lock_s;
    seq_state_t             state;
    seq_state_t             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    reset_cause_t           cause_nxt;
    logic [NUM_DOMAINS-1:0] dom_nxt;
    logic [31:0]            boot_addr_nxt;
    logic                   lock_lost;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next-state, next-count and next-output decode; outputs are registered
    // from these so every output already reflects the state being entered.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_nxt     = state;
        cause_nxt     = reset_cause;
        boot_addr_nxt = boot_addr;
        dom_nxt       = '0;
        cnt_nxt       = cnt;

        // Lock loss outranks a software request in the same cycle.
        lock_lost = !lock_s && (state inside {HOLD, RELEASE, FETCH_DLY, RUN});

        if (lock_lost) begin
            state_nxt = WAIT_LOCK;
            cause_nxt = CAUSE_LOCK_LOSS;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) state_nxt = FILTER;
                end
                FILTER: begin
                    // A single low sample restarts the whole filter window.
                    if (!lock_s)                 state_nxt = WAIT_LOCK;
                    else if (cnt == FILTER_LAST) state_nxt = HOLD;
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = RELEASE;
                end
                RELEASE: begin
                    if (cnt == RELEASE_LAST) state_nxt = FETCH_DLY;
                end
                FETCH_DLY: begin
                    if (cnt == FETCH_LAST) state_nxt = RUN;
                end
                RUN: begin
                    // Software reset skips the lock filter: the PLL is known good.
                    if (sw_reset_req) begin
                        state_nxt = HOLD;
                        cause_nxt = CAUSE_SOFTWARE;
                    end
                end
                default: state_nxt = WAIT_LOCK;
            endcase
        end

        // Counter restarts on every state change and saturates otherwise.
        if (state_nxt != state) cnt_nxt = '0;
        else if (cnt != CNT_SAT) cnt_nxt = cnt + 1'b1;

        // Boot address is captured only on the cycle HOLD is entered.
        if (state_nxt == HOLD && state != HOLD)
            boot_addr_nxt = boot_sel ? ALT_BOOT_ADDR : BOOT_ADDR;

        // Domain i is out of reset once i*STAGGER_CYCLES RELEASE cycles have
        // elapsed; domain 0 therefore leaves reset on RELEASE entry.
        if (state_nxt == FETCH_DLY || state_nxt == RUN) begin
            dom_nxt = '1;
        end else if (state_nxt == RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++)
                dom_nxt[i] = (CNT_W'(i * STAGGER_CYCLES) <= cnt_nxt);
        end
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_LOCK;
            cnt            <= '0;
            domain_reset_n <= '0;
            fetch_enable   <= 1'b0;
            boot_addr      <= BOOT_ADDR;
            reset_cause    <= CAUSE_POR;
            seq_busy       <= 1'b1;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            domain_reset_n <= dom_nxt;
            fetch_enable   <= (state_nxt == RUN);
            boot_addr      <= boot_addr_nxt;
            reset_cause    <= cause_nxt;
            seq_busy       <= (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_boot_reset_seq.sv
// Directed bench for boot_reset_seq: default instance plus a 4-domain,
// 1-cycle-stagger instance sharing the same inputs.
module tb_boot_reset_seq;

    localparam logic [31:0] BOOT = 32'h1A00_0080;
    localparam logic [31:0] ALT  = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pll_locked;
    logic        sw_reset_req;
    logic        boot_sel;

    logic [1:0]  dom;
    logic        fe;
    logic [31:0] baddr;
    logic [1:0]  cause;
    logic        busy;

    logic [3:0]  dom4;
    logic        fe4;
    logic [31:0] baddr4;
    logic [1:0]  cause4;
    logic        busy4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    boot_reset_seq dut (
        .clk            (clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .boot_sel       (boot_sel),
        .domain_reset_n (dom),
        .fetch_enable   (fe),
        .boot_addr      (baddr),
        .reset_cause    (cause),
        .seq_busy       (busy)
    );

    boot_reset_seq #(
        .NUM_DOMAINS    (4),
        .STAGGER_CYCLES (1)
    ) dut4 (
        .clk            (clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .boot_sel       (boot_sel),
        .domain_reset_n (dom4),
        .fetch_enable   (fe4),
        .boot_addr      (baddr4),
        .reset_cause    (cause4),
        .seq_busy       (busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        reset        = 1'b1;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        boot_sel     = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_dom",   32'(dom),   32'h0);
        check("rst_fe",    32'(fe),    32'h0);
        check("rst_boot",  baddr,      BOOT);
        check("rst_cause", 32'(cause), 32'h0);
        check("rst_busy",  32'(busy),  32'h1);
        check("rst_dom4",  32'(dom4),  32'h0);

        // Power-up: lock_s high after edge 2, FILTER 3..18, HOLD 19..82,
        // RELEASE from 83, RUN at 124 (default) / 119 (4-domain).
        reset      = 1'b0;
        pll_locked = 1'b1;
        cyc        = 0;
        run_to(82);
        check("pu_hold_dom",  32'(dom),  32'h0);
        check("pu_hold_dom4", 32'(dom4), 32'h0);
        run_to(83);
        check("pu_rel0_dom",  32'(dom),  32'h1);
        check("pu_rel0_dom4", 32'(dom4), 32'h1);
        run_to(84);
        check("pu_rel1_dom4", 32'(dom4), 32'h3);
        run_to(85);
        check("pu_rel2_dom4", 32'(dom4), 32'h7);
        run_to(86);
        check("pu_rel3_dom4", 32'(dom4), 32'hF);
        run_to(90);
        check("pu_stag_dom",  32'(dom),  32'h1);
        run_to(91);
        check("pu_d1_dom",    32'(dom),  32'h3);
        run_to(118);
        check("pu_fe4_early", 32'(fe4),  32'h0);
        run_to(119);
        check("pu_fe4",       32'(fe4),  32'h1);
        check("pu_busy4",     32'(busy4), 32'h0);
        run_to(123);
        check("pu_fe_early",  32'(fe),   32'h0);
        check("pu_busy_early", 32'(busy), 32'h1);
        run_to(124);
        check("pu_fe",        32'(fe),    32'h1);
        check("pu_busy",      32'(busy),  32'h0);
        check("pu_boot",      baddr,      BOOT);
        check("pu_cause",     32'(cause), 32'h0);

        // Lock glitch during FILTER: refilter from edge 16, RELEASE at 96.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        cyc   = 0;
        run_to(12);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(83);
        check("gl_no_rel83", 32'(dom), 32'h0);
        run_to(95);
        check("gl_no_rel95", 32'(dom), 32'h0);
        check("gl_busy",     32'(busy), 32'h1);
        run_to(96);
        check("gl_rel0",     32'(dom), 32'h1);
        run_to(136);
        check("gl_fe_early", 32'(fe), 32'h0);
        run_to(137);
        check("gl_fe",       32'(fe), 32'h1);

        // Lock loss in RUN: pin low after edge 140, outputs drop at edge 143.
        run_to(140);
        pll_locked = 1'b0;
        run_to(142);
        check("ll_fe_still",  32'(fe),  32'h1);
        check("ll_dom_still", 32'(dom), 32'h3);
        tick();
        check("ll_dom",   32'(dom),   32'h0);
        check("ll_fe",    32'(fe),    32'h0);
        check("ll_cause", 32'(cause), 32'h1);
        check("ll_busy",  32'(busy),  32'h1);
        run_to(145);
        pll_locked = 1'b1;
        run_to(227);
        check("ll_relock_hold", 32'(dom), 32'h0);
        run_to(228);
        check("ll_relock_rel0", 32'(dom), 32'h1);
        run_to(268);
        check("ll_relock_fe_early", 32'(fe), 32'h0);
        run_to(269);
        check("ll_relock_fe",    32'(fe),    32'h1);
        check("ll_cause_sticky", 32'(cause), 32'h1);

        // Software reset in RUN with boot_sel=1: HOLD at 273, RELEASE at 337.
        run_to(272);
        sw_reset_req = 1'b1;
        boot_sel     = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        boot_sel     = 1'b0;
        check("sw_dom",   32'(dom),   32'h0);
        check("sw_fe",    32'(fe),    32'h0);
        check("sw_cause", 32'(cause), 32'h2);
        check("sw_boot",  baddr,      ALT);
        check("sw_busy",  32'(busy),  32'h1);
        // Request during HOLD must be ignored.
        run_to(300);
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        check("sw_ign_boot", baddr, ALT);
        run_to(336);
        check("sw_hold_dom", 32'(dom), 32'h0);
        run_to(337);
        check("sw_rel0",     32'(dom), 32'h1);
        run_to(345);
        check("sw_rel1",     32'(dom), 32'h3);
        run_to(377);
        check("sw_fe_early", 32'(fe), 32'h0);
        run_to(378);
        check("sw_fe",         32'(fe),    32'h1);
        check("sw_boot_keep",  baddr,      ALT);
        check("sw_cause_keep", 32'(cause), 32'h2);

        // Reset mid-RELEASE (only domain 0 out) with a concurrent sw request.
        run_to(380);
        sw_reset_req = 1'b1;
        boot_sel     = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        boot_sel     = 1'b0;
        run_to(446);
        check("mr_dom_pre",  32'(dom), 32'h1);
        check("mr_boot_pre", baddr,    ALT);
        reset        = 1'b1;
        sw_reset_req = 1'b1;
        tick();
        check("mr_dom",   32'(dom),   32'h0);
        check("mr_fe",    32'(fe),    32'h0);
        check("mr_boot",  baddr,      BOOT);
        check("mr_cause", 32'(cause), 32'h0);
        check("mr_busy",  32'(busy),  32'h1);
        sw_reset_req = 1'b0;
        tick();
        check("mr_hold_dom",   32'(dom),   32'h0);
        check("mr_hold_cause", 32'(cause), 32'h0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
